// File: rtl/maze_pkg.sv
// Shared maze-solver types: location width, move direction codes, replay FSM encoding.
// Pure declarations, no logic.
package maze_pkg;
  localparam int LOC_W = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_SEND = 2'b10
  } rp_state_e;
endpackage

// File: rtl/path_stack_loc_step_dir.sv
// loc_step_dir: combinational move decoder between two {row,col} cells, mod-16 wrap.
// Only compiled when PATH_STACK_DIR_EN is defined, since it is the sole user.
`ifdef PATH_STACK_DIR_EN
module loc_step_dir
  import maze_pkg::*;
(
  input  logic [7:0] i_from,
  input  logic [7:0] i_to,
  output logic [1:0] o_dir,
  output logic       o_adj
);
  logic [3:0] w_fr, w_fc, w_tr, w_tc;

  assign w_fr = i_from[7:4];
  assign w_fc = i_from[3:0];
  assign w_tr = i_to[7:4];
  assign w_tc = i_to[3:0];

  always_comb begin
    o_dir = DIR_UP;
    o_adj = 1'b1;
    if (w_tc == w_fc && w_tr == w_fr - 4'd1)      o_dir = DIR_UP;
    else if (w_tr == w_fr && w_tc == w_fc + 4'd1) o_dir = DIR_RIGHT;
    else if (w_tc == w_fc && w_tr == w_fr + 4'd1) o_dir = DIR_DOWN;
    else if (w_tr == w_fr && w_tc == w_fc - 4'd1) o_dir = DIR_LEFT;
    else begin
      o_dir = DIR_UP;
      o_adj = 1'b0;
    end
  end
endmodule
`endif

// File: rtl/path_stack.sv
// path_stack: LIFO of visited cells; top/empStck/full one cycle after push/pop, replay beats 2 cycles after pulse.
// Replay beats held until outReady (1 beat / 2 cycles); PATH_STACK_DIR_EN adds per-beat move direction on outDir.
module path_stack #(
  parameter int DEPTH = 256,
  parameter int PW    = 9,
  parameter int LOC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] dIn,
  output logic [LOC_W-1:0] top,
  output logic             empStck,
  output logic             full,
  output logic             ovf,
  input  logic             replay,
  output logic             busy,
  output logic             outValid,
  input  logic             outReady,
  output logic [LOC_W-1:0] outLoc,
  output logic [1:0]       outDir,
  output logic             outLast
);
  import maze_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LOC_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_sp;
  logic             r_ovf;
  rp_state_e        r_state;
  logic [AW-1:0]    r_idx;
  logic [LOC_W-1:0] r_out_loc;

  rp_state_e        w_state_nxt;
  logic [PW-1:0]    w_sp_m1, w_sp_nxt;
  logic [AW-1:0]    w_top_addr, w_wr_addr;
  logic             w_empty, w_full, w_busy, w_do_push, w_do_pop;
  logic             w_wr_en, w_ovf_set, w_start, w_last;

  assign w_sp_m1    = r_sp - 1'b1;
  assign w_top_addr = w_sp_m1[AW-1:0];
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == PW'(DEPTH));
  assign w_busy     = (r_state != ST_IDLE);
  assign w_do_push  = push & ~w_busy;
  assign w_do_pop   = pop & ~w_busy;

  // Push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_sp[AW-1:0];
    w_sp_nxt  = r_sp;
    w_ovf_set = 1'b0;
    if (w_do_push && w_do_pop && !w_empty) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_top_addr;
    end else if (w_do_push) begin
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_sp_nxt = r_sp + 1'b1;
      end
    end else if (w_do_pop && !w_empty) begin
      w_sp_nxt = w_sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= dIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_sp <= w_sp_nxt;
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  assign top     = w_empty ? '0 : r_mem[w_top_addr];
  assign empStck = w_empty;
  assign full    = w_full;
  assign ovf     = r_ovf;
  assign busy    = w_busy;

  assign w_start = (r_state == ST_IDLE) && replay && !w_empty;
  assign w_last  = (r_idx == w_top_addr);

  always_comb begin
    w_state_nxt = r_state;
    outValid    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_READ;
      ST_READ: w_state_nxt = ST_SEND;
      ST_SEND: begin
        outValid = 1'b1;
        if (outReady) w_state_nxt = w_last ? ST_IDLE : ST_READ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_out_loc <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (w_start) r_idx <= '0;
        ST_READ: r_out_loc <= r_mem[r_idx];
        ST_SEND: if (outReady && !w_last) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign outLoc  = r_out_loc;
  assign outLast = outValid & w_last;

`ifdef PATH_STACK_DIR_EN
  logic [LOC_W-1:0] r_prev_loc;
  logic [1:0]       w_step_dir;
  logic             w_step_adj;

  // outLoc still holds the previous beat while in READ, so capture it as the origin.
  always_ff @(posedge clk) begin
    if (rst) r_prev_loc <= '0;
    else if (r_state == ST_READ && r_idx != '0) r_prev_loc <= r_out_loc;
  end

  loc_step_dir u_step (
    .i_from (r_prev_loc),
    .i_to   (r_out_loc),
    .o_dir  (w_step_dir),
    .o_adj  (w_step_adj)
  );

  assign outDir = (outValid && r_idx != '0 && w_step_adj) ? w_step_dir : 2'b00;
`else
  assign outDir = 2'b00;
`endif
endmodule
